// File: rtl/regfile_operand_fwd_if.sv
// Operand-fetch bus between decode/execute and the register file.
// The master modport drives decode selects, the execute result and the write-back.
interface regfile_operand_fwd_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            in_valid;
  logic            flush;
  logic [AW-1:0]   rs1_sel;
  logic [AW-1:0]   rs2_sel;
  logic            ex_en;
  logic [AW-1:0]   ex_rd;
  logic [XLEN-1:0] ex_data;
  logic            wb_en;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            op_valid;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [AW-1:0]   dbg_sel;
  logic [XLEN-1:0] dbg_val;

  modport master (
    output in_valid, flush, rs1_sel, rs2_sel, ex_en, ex_rd, ex_data,
    output wb_en, wb_rd, wb_data, dbg_sel,
    input  op_valid, rs1_val, rs2_val, dbg_val
  );

  modport slave (
    input  in_valid, flush, rs1_sel, rs2_sel, ex_en, ex_rd, ex_data,
    input  wb_en, wb_rd, wb_data, dbg_sel,
    output op_valid, rs1_val, rs2_val, dbg_val
  );
endinterface

// File: rtl/regfile_operand_fwd.sv
// 32x32 integer register file with write-back commit and registered, forwarded
// rs1/rs2 operand capture for the execute stage.
module regfile_operand_fwd #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input logic                 clk,
  input logic                 rst,
  regfile_operand_fwd_if.slave bus
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  logic            op_valid_q, op_valid_d;
  logic [XLEN-1:0] rs1_val_q, rs1_val_d;
  logic [XLEN-1:0] rs2_val_q, rs2_val_d;

  logic            ex_en, wb_en;
  logic [AW-1:0]   ex_rd, wb_rd;
  logic [XLEN-1:0] ex_data, wb_data;

  assign ex_en   = bus.ex_en;
  assign ex_rd   = bus.ex_rd;
  assign ex_data = bus.ex_data;
  assign wb_en   = bus.wb_en;
  assign wb_rd   = bus.wb_rd;
  assign wb_data = bus.wb_data;

  // Newest producer first: execute result, then same-edge write-back, then array.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic [AW-1:0]   sel,
    input logic            f_ex_en,
    input logic [AW-1:0]   f_ex_rd,
    input logic [XLEN-1:0] f_ex_data,
    input logic            f_wb_en,
    input logic [AW-1:0]   f_wb_rd,
    input logic [XLEN-1:0] f_wb_data,
    input logic [XLEN-1:0] f_arr
  );
    if (sel == '0) begin
      return '0;
    end else if (f_ex_en && (f_ex_rd == sel)) begin
      return f_ex_data;
    end else if (f_wb_en && (f_wb_rd == sel)) begin
      return f_wb_data;
    end
    return f_arr;
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_rd != '0)) begin
      regs_d[wb_rd] = wb_data;
    end
    regs_d[0] = '0;
  end

  always_comb begin
    op_valid_d = bus.in_valid & ~bus.flush;
    rs1_val_d  = '0;
    rs2_val_d  = '0;
    if (!bus.flush) begin
      rs1_val_d = pick_operand(bus.rs1_sel, ex_en, ex_rd, ex_data, wb_en, wb_rd, wb_data,
                               regs_q[bus.rs1_sel]);
      rs2_val_d = pick_operand(bus.rs2_sel, ex_en, ex_rd, ex_data, wb_en, wb_rd, wb_data,
                               regs_q[bus.rs2_sel]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
      op_valid_q <= 1'b0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      op_valid_q <= op_valid_d;
      rs1_val_q  <= rs1_val_d;
      rs2_val_q  <= rs2_val_d;
    end
  end

  assign bus.op_valid = op_valid_q;
  assign bus.rs1_val  = rs1_val_q;
  assign bus.rs2_val  = rs2_val_q;
  assign bus.dbg_val  = (bus.dbg_sel == '0) ? '0 : regs_q[bus.dbg_sel];

endmodule

// File: doc/regfile_operand_fwd.md
Name: regfile_operand_fwd

Overview:
- Decode/operand-fetch end of the execute-stage write-back path.
- Consumes the outputs of the execute pipeline register (write enable, destination select, ALU result) and commits them into a 32x32 integer register file.
- Supplies registered rs1/rs2 operands to the execute stage. Newer in-flight results are forwarded ahead of the array.
- Sits between decode and the execute-stage operand inputs.

Parameters:
- XLEN, 32, data width of registers and operands.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- AW, 5, register select width; must satisfy 2^AW = NREG.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  decode presents a valid instruction this cycle.
- flush  in  1  kill the instruction being captured this cycle.
- rs1_sel  in  AW  source register 1 select.
- rs2_sel  in  AW  source register 2 select.
- ex_en  in  1  execute stage currently producing a result (combinational ALU output).
- ex_rd  in  AW  destination of the execute-stage result.
- ex_data  in  XLEN  execute-stage ALU result.
- wb_en  in  1  write enable from the execute pipeline register.
- wb_rd  in  AW  destination select from the execute pipeline register.
- wb_data  in  XLEN  ALU result from the execute pipeline register.
- op_valid  out  1  registered operands are valid.
- rs1_val  out  XLEN  registered operand 1.
- rs2_val  out  XLEN  registered operand 2.
- dbg_sel  in  AW  debug read select.
- dbg_val  out  XLEN  combinational debug read of the array; no forwarding.

Behaviour:
- Reset (rst=1 at posedge):
  - all NREG array entries <= 0; op_valid, rs1_val, rs2_val <= 0.
  - A wb write presented on the same edge is dropped (reset wins).
- Write-back:
  - At posedge, if wb_en=1 and wb_rd!=0, then array[wb_rd] <= wb_data.
  - wb_rd=0 is ignored; array[0] always reads 0.
- Operand capture: one cycle latency. At each posedge without rst, for each source s in {rs1, rs2}:
  - sel=0 -> 0 (x0 is never forwarded).
  - else ex_en=1 and ex_rd==sel -> ex_data (newest producer, highest priority).
  - else wb_en=1 and wb_rd==sel -> wb_data (same-edge write bypass).
  - else -> array[sel] (pre-edge contents).
- op_valid <= in_valid & ~flush.
- flush=1: op_valid <= 0, and rs1_val, rs2_val <= 0. A write-back on the same edge still commits.
- in_valid=0 without flush: op_valid <= 0; rs1_val/rs2_val still update per the mux (do not care downstream).
- rs1_sel == rs2_sel: both outputs get the identical forwarded value.
- ex_rd == wb_rd == sel with both enables high: ex_data wins; the array still receives wb_data.
- ex_en=1 with ex_rd=0: never forwarded.
- dbg_val = array[dbg_sel], combinational; dbg_sel=0 -> 0.
- No stall input: the decode stage holds the selects and in_valid during stalls. Operands are re-captured every cycle, so they pick up write-backs that complete during the stall.

Test Plan:
- Reset/x0:
  - Stimulus: rst=1 for 2 cycles with wb_en=1, wb_rd=5, wb_data=0xDEADBEEF; then release.
  - Response: dbg_sel=5 -> 0; op_valid=0.
  - Stimulus: write wb_rd=0, data 0x1234, then read rs1_sel=0.
  - Response: rs1_val=0.
- Write then read:
  - Stimulus: wb_en=1, wb_rd=3, wb_data=0x0000_00AA at cycle N; rs1_sel=3, in_valid=1 at cycle N+1.
  - Response: cycle N+2 gives rs1_val=0xAA, op_valid=1.
- Same-edge bypass:
  - Stimulus: wb_rd=7, wb_data=0x55 together with rs2_sel=7, in_valid=1.
  - Response: next cycle rs2_val=0x55; dbg_sel=7 reads 0x55 after the edge.
- Priority:
  - Stimulus: array[9]=0x11; wb_rd=9 with 0x22, ex_rd=9 with 0x33, both enables high; rs1_sel=rs2_sel=9.
  - Response: rs1_val=rs2_val=0x33; array[9] then holds 0x22.
- Flush:
  - Stimulus: in_valid=1, flush=1, rs1_sel=3 (array[3]=0xAA), wb write x4=0x77 on the same edge.
  - Response: op_valid=0, rs1_val=0; dbg_sel=4 -> 0x77.
- Stall re-read:
  - Stimulus: hold rs1_sel=12, in_valid=1 for 3 cycles; wb x12=0x99 commits in cycle 2.
  - Response: rs1_val shows the old value, then 0x99 from the capture on the commit edge onward.
